// File: rtl/controlador_rpn_pkg.sv
// ============================================================================
// Module      : controlador_rpn_pkg
// Description : Shared constants for the RPN ALU controller and its datapath.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package controlador_rpn_pkg;

    // Controller states (2-bit encoding)
    localparam logic [1:0] C_OCIOSO  = 2'd0;
    localparam logic [1:0] C_EXECUTA = 2'd1;
    localparam logic [1:0] C_GRAVA   = 2'd2;
    localparam logic [1:0] C_ERRO    = 2'd3;

    // Opcodes shared with the ALU
    localparam logic [2:0] C_OP_ADD = 3'b000;
    localparam logic [2:0] C_OP_SUB = 3'b001;
    localparam logic [2:0] C_OP_AND = 3'b010;
    localparam logic [2:0] C_OP_OR  = 3'b011;
    localparam logic [2:0] C_OP_XOR = 3'b100;
    localparam logic [2:0] C_OP_NOT = 3'b111;

    // erro_tipo codes
    localparam logic [1:0] C_ERRO_NENHUM     = 2'b00;
    localparam logic [1:0] C_ERRO_OVERFLOW   = 2'b01;
    localparam logic [1:0] C_ERRO_UNDERFLOW  = 2'b10;

    typedef struct packed {
        logic carry;
        logic overflow;
        logic zero;
        logic negative;
    } flags_t;

    function automatic logic [1:0] operandos_necessarios(input logic [2:0] op,
                                                         input logic [2:0] op_not);
        return (op == op_not) ? 2'd1 : 2'd2;
    endfunction

endpackage

`default_nettype wire

// File: rtl/controlador_rpn_pilha_operandos.sv
// ============================================================================
// Module      : pilha_operandos
// Description : Register-based operand stack with push, pop2_push and
//               replace_top operations plus level/full/empty status.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pilha_operandos
    import controlador_rpn_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int NW    = IW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_push,
    input  logic             i_pop2_push,
    input  logic             i_replace_top,
    input  logic [WIDTH-1:0] i_dado,
    input  logic [WIDTH-1:0] i_resultado,
    output logic [WIDTH-1:0] o_topo,
    output logic [WIDTH-1:0] o_segundo,
    output logic [NW-1:0]    o_nivel,
    output logic             o_full,
    output logic             o_empty
);

    logic [WIDTH-1:0] r_pilha [DEPTH];
    logic [NW-1:0]    r_nivel;
    logic [IW-1:0]    w_idx_push;
    logic [IW-1:0]    w_idx_topo;
    logic [IW-1:0]    w_idx_seg;

    // Modular index arithmetic: a full stack wraps nivel to 0, and 0-1 is DEPTH-1
    assign w_idx_push = r_nivel[IW-1:0];
    assign w_idx_topo = r_nivel[IW-1:0] - IW'(1);
    assign w_idx_seg  = r_nivel[IW-1:0] - IW'(2);

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_pilha[i] <= '0;
            end
            r_nivel <= '0;
        end else if (i_push) begin
            r_pilha[w_idx_push] <= i_dado;
            r_nivel             <= r_nivel + NW'(1);
        end else if (i_pop2_push) begin
            r_pilha[w_idx_seg]  <= i_resultado;
            r_pilha[w_idx_topo] <= '0;
            r_nivel             <= r_nivel - NW'(1);
        end else if (i_replace_top) begin
            r_pilha[w_idx_topo] <= i_resultado;
        end
    end

    assign o_topo    = r_pilha[w_idx_topo];
    assign o_segundo = r_pilha[w_idx_seg];
    assign o_nivel   = r_nivel;
    assign o_full    = (r_nivel == NW'(DEPTH));
    assign o_empty   = (r_nivel == '0);

endmodule

`default_nettype wire

// File: rtl/controlador_rpn.sv
// ============================================================================
// Module      : controlador_rpn
// Description : Sequencing controller for the 8-bit RPN ALU: owns the operand
//               stack, feeds the ALU and writes its result back.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module controlador_rpn
    import controlador_rpn_pkg::*;
#(
    parameter  int         WIDTH  = 8,
    parameter  int         DEPTH  = 4,
    parameter  logic [2:0] OP_NOT = C_OP_NOT,
    localparam int         NW     = ((DEPTH > 1) ? $clog2(DEPTH) : 1) + 1
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] dado_in,
    input  logic [2:0]       op_in,
    input  logic             press_enter,
    input  logic             press_exec,
    input  logic             press_clear,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] alu_result,
    input  logic [3:0]       alu_flags,
    output logic [WIDTH-1:0] topo,
    output logic [NW-1:0]    nivel,
    output logic [3:0]       flags,
    output logic             ocupado,
    output logic             erro,
    output logic [1:0]       erro_tipo
);

    logic [1:0]       r_estado;
    logic [WIDTH-1:0] r_alu_a;
    logic [WIDTH-1:0] r_alu_b;
    logic [2:0]       r_alu_op;
    flags_t           r_flags;
    logic [1:0]       r_erro_tipo;

    logic [WIDTH-1:0] w_topo_bruto;
    logic [WIDTH-1:0] w_segundo;
    logic [NW-1:0]    w_nivel;
    logic             w_cheia;
    logic             w_vazia;
    logic             w_unario_in;
    logic             w_unario_lat;
    logic             w_operandos_ok;
    logic             w_push;
    logic             w_pop2_push;
    logic             w_replace_top;

    assign w_unario_in    = (op_in == OP_NOT);
    assign w_unario_lat   = (r_alu_op == OP_NOT);
    assign w_operandos_ok = (w_nivel >= NW'(operandos_necessarios(op_in, OP_NOT)));

    // Clear outranks everything; exec outranks enter in the same cycle
    assign w_push        = (r_estado == C_OCIOSO) && !press_clear && !press_exec
                           && press_enter && !w_cheia;
    assign w_pop2_push   = (r_estado == C_GRAVA) && !press_clear && !w_unario_lat;
    assign w_replace_top = (r_estado == C_GRAVA) && !press_clear && w_unario_lat;

    pilha_operandos #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_pilha (
        .clk           (CLOCK),
        .rst           (RESET),
        .i_clear       (press_clear),
        .i_push        (w_push),
        .i_pop2_push   (w_pop2_push),
        .i_replace_top (w_replace_top),
        .i_dado        (dado_in),
        .i_resultado   (alu_result),
        .o_topo        (w_topo_bruto),
        .o_segundo     (w_segundo),
        .o_nivel       (w_nivel),
        .o_full        (w_cheia),
        .o_empty       (w_vazia)
    );

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_estado    <= C_OCIOSO;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_op    <= '0;
            r_flags     <= '0;
            r_erro_tipo <= C_ERRO_NENHUM;
        end else if (press_clear) begin
            r_estado    <= C_OCIOSO;
            r_erro_tipo <= C_ERRO_NENHUM;
        end else begin
            case (r_estado)
                C_OCIOSO: begin
                    if (press_exec) begin
                        if (!w_operandos_ok) begin
                            r_estado    <= C_ERRO;
                            r_erro_tipo <= C_ERRO_UNDERFLOW;
                        end else begin
                            r_alu_op <= op_in;
                            r_alu_a  <= w_unario_in ? w_topo_bruto : w_segundo;
                            r_alu_b  <= w_unario_in ? '0 : w_topo_bruto;
                            r_estado <= C_EXECUTA;
                        end
                    end else if (press_enter && w_cheia) begin
                        r_estado    <= C_ERRO;
                        r_erro_tipo <= C_ERRO_OVERFLOW;
                    end
                end
                C_EXECUTA: r_estado <= C_GRAVA;
                C_GRAVA: begin
                    r_flags  <= alu_flags;
                    r_estado <= C_OCIOSO;
                end
                default: r_estado <= r_estado;
            endcase
        end
    end

    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign alu_op    = r_alu_op;
    assign topo      = w_vazia ? '0 : w_topo_bruto;
    assign nivel     = w_nivel;
    assign flags     = r_flags;
    assign ocupado   = (r_estado == C_EXECUTA) || (r_estado == C_GRAVA);
    assign erro      = (r_estado == C_ERRO);
    assign erro_tipo = r_erro_tipo;

endmodule

`default_nettype wire

// File: tb/tb_controlador_rpn.sv
// ============================================================================
// Module      : tb_controlador_rpn
// Description : Scoreboard bench for controlador_rpn with a behavioural ALU.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_controlador_rpn;

    logic       CLOCK = 1'b0;
    logic       RESET = 1'b1;
    logic [7:0] dado_in = '0;
    logic [2:0] op_in = '0;
    logic       press_enter = 1'b0;
    logic       press_exec = 1'b0;
    logic       press_clear = 1'b0;
    logic [7:0] alu_a, alu_b, alu_result, topo;
    logic [2:0] alu_op, nivel;
    logic [3:0] alu_flags, flags;
    logic       ocupado, erro;
    logic [1:0] erro_tipo;

    controlador_rpn #(.WIDTH(8), .DEPTH(4), .OP_NOT(3'b111)) dut (
        .CLOCK       (CLOCK),
        .RESET       (RESET),
        .dado_in     (dado_in),
        .op_in       (op_in),
        .press_enter (press_enter),
        .press_exec  (press_exec),
        .press_clear (press_clear),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_op      (alu_op),
        .alu_result  (alu_result),
        .alu_flags   (alu_flags),
        .topo        (topo),
        .nivel       (nivel),
        .flags       (flags),
        .ocupado     (ocupado),
        .erro        (erro),
        .erro_tipo   (erro_tipo)
    );

    always #5 CLOCK = ~CLOCK;

    // Behavioural ALU: flags = {carry, overflow, zero, negative}; SUB carry = borrow
    always_comb begin
        logic [8:0] soma;
        soma       = '0;
        alu_result = '0;
        alu_flags  = '0;
        case (alu_op)
            3'b000: begin
                soma         = {1'b0, alu_a} + {1'b0, alu_b};
                alu_result   = soma[7:0];
                alu_flags[3] = soma[8];
                alu_flags[2] = (alu_a[7] == alu_b[7]) && (alu_result[7] != alu_a[7]);
            end
            3'b001: begin
                alu_result   = alu_a - alu_b;
                alu_flags[3] = (alu_a < alu_b);
                alu_flags[2] = (alu_a[7] != alu_b[7]) && (alu_result[7] != alu_a[7]);
            end
            3'b010: alu_result = alu_a & alu_b;
            3'b011: alu_result = alu_a | alu_b;
            3'b100: alu_result = alu_a ^ alu_b;
            3'b111: alu_result = ~alu_a;
            default: alu_result = '0;
        endcase
        alu_flags[1] = (alu_result == 8'h00);
        alu_flags[0] = alu_result[7];
    end

    typedef struct {
        logic [7:0] topo;
        logic [2:0] nivel;
        logic [3:0] flags;
        logic       erro;
        logic [1:0] tipo;
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] op;
        int         busy;
    } esperado_t;

    esperado_t q[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    logic sonda   = 1'b0;

    function automatic esperado_t esp(input logic [7:0] t, input logic [2:0] n,
                                      input logic [3:0] f, input logic e,
                                      input logic [1:0] tp, input logic [7:0] a,
                                      input logic [7:0] b, input logic [2:0] op,
                                      input int busy);
        esperado_t r;
        r.topo = t; r.nivel = n; r.flags = f; r.erro = e; r.tipo = tp;
        r.a = a; r.b = b; r.op = op; r.busy = busy;
        return r;
    endfunction

    task automatic chk(input string nome, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nome, act, exp, $time);
        end
    endtask

    // Monitor: pops an expectation on write-back/abort end, error entry or probe
    initial begin
        logic busy_prev = 1'b0;
        logic erro_prev = 1'b0;
        int   n_busy    = 0;
        forever begin
            @(negedge CLOCK);
            if (ocupado === 1'b1) n_busy++;
            if ((busy_prev === 1'b1 && ocupado === 1'b0) ||
                (erro_prev === 1'b0 && erro === 1'b1) || sonda) begin
                if (q.size() == 0) begin
                    chk("evento_inesperado", 32'd1, 32'd0);
                end else begin
                    esperado_t e;
                    e = q.pop_front();
                    chk("topo", 32'(topo), 32'(e.topo));
                    chk("nivel", 32'(nivel), 32'(e.nivel));
                    chk("flags", 32'(flags), 32'(e.flags));
                    chk("erro", 32'(erro), 32'(e.erro));
                    chk("erro_tipo", 32'(erro_tipo), 32'(e.tipo));
                    chk("alu_a", 32'(alu_a), 32'(e.a));
                    chk("alu_b", 32'(alu_b), 32'(e.b));
                    chk("alu_op", 32'(alu_op), 32'(e.op));
                    if (e.busy >= 0) chk("ciclos_ocupado", 32'(n_busy), 32'(e.busy));
                end
            end
            if (ocupado !== 1'b1) n_busy = 0;
            busy_prev = ocupado;
            erro_prev = erro;
        end
    end

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic pulso(input logic e, input logic x, input logic c,
                         input logic [7:0] d, input logic [2:0] op);
        press_enter = e; press_exec = x; press_clear = c;
        dado_in = d; op_in = op;
        tick();
        press_enter = 1'b0; press_exec = 1'b0; press_clear = 1'b0;
    endtask

    task automatic empilha(input logic [7:0] d);
        pulso(1'b1, 1'b0, 1'b0, d, 3'b000);
    endtask

    task automatic executa(input logic [2:0] op);
        pulso(1'b0, 1'b1, 1'b0, 8'h00, op);
    endtask

    task automatic limpa();
        pulso(1'b0, 1'b0, 1'b1, 8'h00, 3'b000);
    endtask

    task automatic sondar(input esperado_t e);
        q.push_back(e);
        sonda = 1'b1;
        tick();
        sonda = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) tick();
        sondar(esp(8'h00, 3'd0, 4'b0000, 1'b0, 2'b00, 8'h00, 8'h00, 3'b000, -1));
        RESET = 1'b0;
        tick();

        // 05 + 03 = 08
        empilha(8'h05); empilha(8'h03);
        q.push_back(esp(8'h08, 3'd1, 4'b0000, 1'b0, 2'b00, 8'h05, 8'h03, 3'b000, 2));
        executa(3'b000);
        repeat (4) tick();

        // FF + 01 = 00 with carry and zero
        limpa();
        empilha(8'hFF); empilha(8'h01);
        q.push_back(esp(8'h00, 3'd1, 4'b1010, 1'b0, 2'b00, 8'hFF, 8'h01, 3'b000, 2));
        executa(3'b000);
        repeat (4) tick();

        // NOT 0F = F0, then binary op with one operand underflows
        limpa();
        empilha(8'h0F);
        q.push_back(esp(8'hF0, 3'd1, 4'b0001, 1'b0, 2'b00, 8'h0F, 8'h00, 3'b111, 2));
        executa(3'b111);
        repeat (4) tick();
        q.push_back(esp(8'hF0, 3'd1, 4'b0001, 1'b1, 2'b10, 8'h0F, 8'h00, 3'b111, -1));
        executa(3'b000);
        repeat (2) tick();
        limpa();

        // Stack overflow on fifth push; enter ignored in error; clear recovers
        empilha(8'h11); empilha(8'h22); empilha(8'h33); empilha(8'h44);
        q.push_back(esp(8'h44, 3'd4, 4'b0001, 1'b1, 2'b01, 8'h0F, 8'h00, 3'b111, -1));
        empilha(8'h55);
        tick();
        empilha(8'h66);
        sondar(esp(8'h44, 3'd4, 4'b0001, 1'b1, 2'b01, 8'h0F, 8'h00, 3'b111, -1));
        limpa();
        sondar(esp(8'h00, 3'd0, 4'b0001, 1'b0, 2'b00, 8'h0F, 8'h00, 3'b111, -1));

        // enter+exec together: exec wins; enter during EXECUTA dropped. 07 - 0A = FD
        empilha(8'h07); empilha(8'h0A);
        q.push_back(esp(8'hFD, 3'd1, 4'b1001, 1'b0, 2'b00, 8'h07, 8'h0A, 3'b001, 2));
        pulso(1'b1, 1'b1, 1'b0, 8'h99, 3'b001);
        empilha(8'h77);
        repeat (4) tick();

        // RESET during EXECUTA aborts the write-back
        empilha(8'h02);
        q.push_back(esp(8'h00, 3'd0, 4'b0000, 1'b0, 2'b00, 8'h00, 8'h00, 3'b000, 1));
        executa(3'b010);
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        repeat (2) tick();

        // Clear during GRAVA aborts the write-back and keeps the old flags
        empilha(8'h80); empilha(8'h05);
        q.push_back(esp(8'h00, 3'd0, 4'b0000, 1'b0, 2'b00, 8'h80, 8'h05, 3'b011, 2));
        executa(3'b011);
        tick();
        limpa();
        repeat (2) tick();

        // 0C XOR 05 = 09
        empilha(8'h0C); empilha(8'h05);
        q.push_back(esp(8'h09, 3'd1, 4'b0000, 1'b0, 2'b00, 8'h0C, 8'h05, 3'b100, 2));
        executa(3'b100);
        repeat (4) tick();

        chk("expectativas_pendentes", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
